// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one external memory bus between port 0 (CRP core) and port 1 (loader).
// Define MEM_ARB_LOCK_EN to let port 0 keep the bus for back-to-back accesses while lock0 is held.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    output logic              ready0,
    output logic              ready1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] memReqBus,
    output logic              memWriteReq,
    input  logic [DATA_W-1:0] memReadBus,
    output logic              busy,
    output logic              grantId
);

    generate
        if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
            $error("mem_bus_arbiter: READ_LAT must be in 1..15");
        end
        if (DATA_W > ADDR_W) begin : g_bad_data_w
            $error("mem_bus_arbiter: DATA_W must not exceed ADDR_W");
        end
    endgenerate

    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RWAIT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          cnt_q;
    logic                gid_q;
    logic [1:0]          ready_q;
    logic [DATA_W-1:0]   rdata_q [2];
    logic [ADDR_W-1:0]   bus_q;
    logic                wr_q;
    logic                busy_q;

    logic                lock_hold;
    logic                win_d;
    logic                win_we_d;
    logic [ADDR_W-1:0]   win_addr_d;
    logic [DATA_W-1:0]   win_wdata_d;

`ifdef MEM_ARB_LOCK_EN
    // Lock is armed by a port-0 DONE with lock0 high and lives for exactly the following IDLE cycle.
    logic lock_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            lock_q <= lock0 & ~gid_q;
        end else if (state_q == S_IDLE) begin
            lock_q <= 1'b0;
        end
    end

    assign lock_hold = lock_q & req0;
`else
    logic unused_lock0;
    assign unused_lock0 = lock0;
    assign lock_hold    = 1'b0;
`endif

    // Winner selection: a lone requester wins; on a tie the port that did not win last time goes.
    always_comb begin
        win_d = 1'b0;
        if (lock_hold) begin
            win_d = 1'b0;
        end else if (req0 && req1) begin
            win_d = ~gid_q;
        end else if (req1) begin
            win_d = 1'b1;
        end
        win_we_d    = win_d ? we1    : we0;
        win_addr_d  = win_d ? addr1  : addr0;
        win_wdata_d = win_d ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            gid_q      <= 1'b1;
            ready_q    <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            bus_q      <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ready_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        state_q <= S_ADDR;
                        gid_q   <= win_d;
                        we_q    <= win_we_d;
                        addr_q  <= win_addr_d;
                        wdata_q <= win_wdata_d;
                        bus_q   <= win_addr_d;
                        wr_q    <= win_we_d;
                        busy_q  <= 1'b1;
                    end else begin
                        bus_q  <= '0;
                        wr_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (we_q) begin
                        state_q <= S_WDATA;
                        bus_q   <= ADDR_W'(wdata_q);
                        wr_q    <= 1'b1;
                    end else begin
                        state_q <= S_RWAIT;
                        bus_q   <= addr_q;
                        wr_q    <= 1'b0;
                        cnt_q   <= LAT_M1;
                    end
                end
                S_WDATA: begin
                    state_q        <= S_DONE;
                    bus_q          <= '0;
                    wr_q           <= 1'b0;
                    ready_q[gid_q] <= 1'b1;
                end
                S_RWAIT: begin
                    // The edge closing the last wait cycle is the only sampling point for memReadBus.
                    if (cnt_q == 4'd0) begin
                        state_q        <= S_DONE;
                        bus_q          <= '0;
                        wr_q           <= 1'b0;
                        ready_q[gid_q] <= 1'b1;
                        rdata_q[gid_q] <= memReadBus;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    bus_q   <= '0;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    bus_q   <= '0;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready0      = ready_q[0];
    assign ready1      = ready_q[1];
    assign rdata0      = rdata_q[0];
    assign rdata1      = rdata_q[1];
    assign memReqBus   = bus_q;
    assign memWriteReq = wr_q;
    assign busy        = busy_q;
    assign grantId     = gid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single transactions plus hand-written multi-cycle sequences.
module tb_mem_bus_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, memReadBus = '0;
    logic          ready0, ready1, memWriteReq, busy, grantId;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] memReqBus;

    // second instance with a longer read latency
    logic          q_req0 = 1'b0, q_req1 = 1'b0, q_we0 = 1'b0, q_we1 = 1'b0, q_lock0 = 1'b0;
    logic [AW-1:0] q_addr0 = '0, q_addr1 = '0;
    logic [DW-1:0] q_wdata0 = '0, q_wdata1 = '0, q_mrb = '0;
    logic          q_ready0, q_ready1, q_wr, q_busy, q_gid;
    logic [DW-1:0] q_rdata0, q_rdata1;
    logic [AW-1:0] q_bus;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0),
        .ready0(ready0), .ready1(ready1), .rdata0(rdata0), .rdata1(rdata1),
        .memReqBus(memReqBus), .memWriteReq(memWriteReq), .memReadBus(memReadBus),
        .busy(busy), .grantId(grantId)
    );

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset), .req0(q_req0), .req1(q_req1), .we0(q_we0), .we1(q_we1),
        .addr0(q_addr0), .addr1(q_addr1), .wdata0(q_wdata0), .wdata1(q_wdata1), .lock0(q_lock0),
        .ready0(q_ready0), .ready1(q_ready1), .rdata0(q_rdata0), .rdata1(q_rdata1),
        .memReqBus(q_bus), .memWriteReq(q_wr), .memReadBus(q_mrb),
        .busy(q_busy), .grantId(q_gid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic          r0, r1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1, rd;
        logic          gid;
        logic [AW-1:0] bus1;
        logic          wr1;
        logic [AW-1:0] bus2;
        logic          wr2;
        logic [1:0]    rdy;
        logic [DW-1:0] rd0, rd1;
    } vec_t;

    vec_t vecs [6];
    logic exp_gid [4];

    initial begin
        //            r0    r1    w0    w1    a0        a1        d0     d1     rd    | gid  bus1      wr1   bus2      wr2   rdy    rd0    rd1
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 15'h1234, 15'h0000, 8'h00, 8'h00, 8'hA5, 1'b0, 15'h1234, 1'b0, 15'h1234, 1'b0, 2'b01, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 15'h0000, 15'h7FFF, 8'h00, 8'h3C, 8'h00, 1'b1, 15'h7FFF, 1'b1, 15'h003C, 1'b1, 2'b10, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 15'h0001, 15'h0002, 8'h55, 8'h00, 8'hEE, 1'b0, 15'h0001, 1'b1, 15'h0055, 1'b1, 2'b01, 8'hA5, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 15'h0003, 15'h0ABC, 8'h00, 8'h00, 8'h7E, 1'b1, 15'h0ABC, 1'b0, 15'h0ABC, 1'b0, 2'b10, 8'hA5, 8'h7E};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 15'h0000, 15'h4000, 8'h00, 8'h00, 8'h81, 1'b1, 15'h4000, 1'b0, 15'h4000, 1'b0, 2'b10, 8'hA5, 8'h81};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 15'h2AAA, 15'h1111, 8'h00, 8'h99, 8'hC3, 1'b0, 15'h2AAA, 1'b0, 15'h2AAA, 1'b0, 2'b01, 8'hC3, 8'h81};

        // reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst bus", memReqBus, 0);
        check("rst wr", memWriteReq, 0);
        check("rst ready", {ready1, ready0}, 0);
        check("rst rdata0", rdata0, 0);
        check("rst rdata1", rdata1, 0);
        check("rst busy", busy, 0);
        check("rst grantId", grantId, 1);
        reset = 1'b0;

        // table of single transactions; inputs scrambled after grant must not matter
        for (int i = 0; i < 6; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; we0 = vecs[i].w0; we1 = vecs[i].w1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
            memReadBus = vecs[i].rd;
            @(posedge clk); #1;
            check($sformatf("v%0d c1 grantId", i), grantId, vecs[i].gid);
            check($sformatf("v%0d c1 bus", i), memReqBus, vecs[i].bus1);
            check($sformatf("v%0d c1 wr", i), memWriteReq, vecs[i].wr1);
            check($sformatf("v%0d c1 busy", i), busy, 1);
            check($sformatf("v%0d c1 ready", i), {ready1, ready0}, 0);
            req0 = 1'b0; req1 = 1'b0; we0 = ~we0; we1 = ~we1;
            addr0 = ~addr0; addr1 = ~addr1; wdata0 = ~wdata0; wdata1 = ~wdata1;
            @(posedge clk); #1;
            check($sformatf("v%0d c2 bus", i), memReqBus, vecs[i].bus2);
            check($sformatf("v%0d c2 wr", i), memWriteReq, vecs[i].wr2);
            @(posedge clk); #1;
            check($sformatf("v%0d c3 ready", i), {ready1, ready0}, vecs[i].rdy);
            check($sformatf("v%0d c3 bus", i), memReqBus, 0);
            check($sformatf("v%0d c3 wr", i), memWriteReq, 0);
            check($sformatf("v%0d c3 rdata0", i), rdata0, vecs[i].rd0);
            check($sformatf("v%0d c3 rdata1", i), rdata1, vecs[i].rd1);
            @(posedge clk); #1;
            check($sformatf("v%0d c4 busy", i), busy, 0);
            check($sformatf("v%0d c4 ready", i), {ready1, ready0}, 0);
            $display("[TB] vec %0d: port %0d %s done", i, vecs[i].gid,
                     (vecs[i].gid ? vecs[i].w1 : vecs[i].w0) ? "write" : "read");
        end

        // both requests held from reset: strict alternation starting with port 0
        do_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 15'h0100; addr1 = 15'h0200; lock0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rr%0d grantId", k), grantId, k % 2);
            check($sformatf("rr%0d bus", k), memReqBus, (k % 2) ? 15'h0200 : 15'h0100);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check($sformatf("rr%0d ready", k), {ready1, ready0}, (k % 2) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            check($sformatf("rr%0d idle busy", k), busy, 0);
            $display("[TB] rr grant %0d: port %0d", k, grantId);
        end
        req0 = 1'b0; req1 = 1'b0;

        // lock0 held for two port-0 accesses, then released
`ifdef MEM_ARB_LOCK_EN
        exp_gid[0] = 1'b0; exp_gid[1] = 1'b0; exp_gid[2] = 1'b0; exp_gid[3] = 1'b1;
`else
        exp_gid[0] = 1'b0; exp_gid[1] = 1'b1; exp_gid[2] = 1'b0; exp_gid[3] = 1'b1;
`endif
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lock0 = (k < 2);
            @(posedge clk); #1;
            check($sformatf("lock%0d grantId", k), grantId, exp_gid[k]);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check($sformatf("lock%0d ready", k), {ready1, ready0}, exp_gid[k] ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            $display("[TB] lock grant %0d: port %0d lock0=%0d", k, exp_gid[k], lock0);
        end
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;

        // READ_LAT=4: data changes during the third wait cycle, sampled only at the end of the fourth
        @(posedge clk); #1;
        q_req0 = 1'b1; q_addr0 = 15'h0100; q_mrb = 8'h11;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                q_req0 = 1'b0;
                check("lat4 c1 bus", q_bus, 15'h0100);
            end
            if (c == 4) q_mrb = 8'h22;
            if (c == 5) begin
                check("lat4 c5 bus", q_bus, 15'h0100);
                check("lat4 c5 wr", q_wr, 0);
            end
            check($sformatf("lat4 c%0d ready0", c), q_ready0, (c == 6));
            if (c == 6) check("lat4 rdata0", q_rdata0, 8'h22);
        end
        $display("[TB] lat4 read: rdata0=%0h", q_rdata0);

        // reset during the address phase of a write, request re-arbitrated afterwards
        req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0555; wdata1 = 8'h66;
        @(posedge clk); #1;
        check("rstw c1 bus", memReqBus, 15'h0555);
        check("rstw c1 wr", memWriteReq, 1);
        #2 reset = 1'b1;
        #1;
        check("rstw abort bus", memReqBus, 0);
        check("rstw abort wr", memWriteReq, 0);
        check("rstw abort busy", busy, 0);
        check("rstw abort ready", {ready1, ready0}, 0);
        check("rstw abort grantId", grantId, 1);
        check("rstw abort rdata0", rdata0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstw regrant bus", memReqBus, 15'h0555);
        check("rstw regrant wr", memWriteReq, 1);
        check("rstw regrant gid", grantId, 1);
        req1 = 1'b0;
        @(posedge clk); #1;
        check("rstw wdata bus", memReqBus, 15'h0066);
        @(posedge clk); #1;
        check("rstw ready", {ready1, ready0}, 2'b10);
        @(posedge clk); #1;
        check("rstw idle busy", busy, 0);
        $display("[TB] reset-abort write: re-granted port %0d", grantId);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
